microsequencer: RTL and testbench
=================================

Name: microsequencer

Overview:
- Next-address generator that closes the microprogram loop around the 32 x 25 control store.
- Each cycle it decodes the nssel/dbin/ire/mem fields of the registered control word and drives the 5-bit control-store address.
- Owns the instruction register, the zero-flag latch, the memory-wait stall and the illegal-instruction halt.
- Sits between the control store and the datapath/memory interface.

Parameters:
AW, 5, control-store address width
CW, 25, control word width
IRW, 16, instruction register width; opcode = IR[IRW-1:IRW-4], mode = IR[IRW-5:IRW-6]
CNTW, 16, instruction counter width

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
controlword  in  CW  registered control word from the control store
mem_rdata  in  IRW  memory read data, the instruction source
mem_ready  in  1  memory access complete this cycle
alu_zero  in  1  ALU zero result
zero_we  in  1  latch alu_zero into the zero flag
address  out  AW  control-store address (next microstate)
ir  out  IRW  instruction register
halted  out  1  sequencer halted on an illegal dispatch
illegal  out  1  one-cycle pulse on an illegal dispatch
instr_count  out  CNTW  instructions dispatched

Behaviour:
- Control word fields, LSB-first:
  - dbin[4:0], nssel[6:5], ire[7], memcntl[10:8]
  - alu[13:11], bdest[16:14], bsrc[19:17], adest[21:20], asrc[24:22]
  - Only dbin, nssel, ire and memcntl are used here.
- Reset (async, reset_n=0):
  - state=RST_HOLD, address=0, ir=0, zero flag=0, halted=0, illegal=0, instr_count=0.
- FSM RST_HOLD: address=0 for exactly one clock after reset release, so the control store loads start0. Then go to RUN.
- FSM RUN: address = next-address function below, combinational from controlword, ir, zero flag, mem_rdata and mem_ready.
- FSM HALT: address=0, halted=1. HALT is left only by reset.
- Stall:
  - Condition: memcntl != 000 and mem_ready=0.
  - Effects: address = upc_q (the last issued address, registered), so the control store reloads the same word.
  - Suppressed while stalled: IR capture, instr_count, dispatch and illegal detection.
- IR capture: ire=1 and not stalled → ir <= mem_rdata at the clock edge.
- Opcode source: dispatch opcode/mode come from mem_rdata when ire=1 (bypass), else from ir.
- nssel=00 → next = dbin.
- nssel=01 (instruction dispatch) → next from opcode/mode, and instr_count+1 (wraps at 2^CNTW):
  - op0 LD: mode00 →15, mode01 →5, mode10 →1
  - op1 ST: mode00 →16, mode01 →5, mode10 →1
  - op2 OP: mode00 →17, mode01 →5, mode10 →1
  - op3 BRZ →9
  - op4 PUSH →21
  - op5 POP →19
  - op6 TEST →14
  - mode is ignored for op3..op6.
- nssel=10 (operation dispatch) → by ir opcode: LD →10, ST →11, OP →12; any other opcode is illegal.
- nssel=11 (zero branch) → next = {dbin[4:1], zero flag}.
- Illegal dispatch:
  - Triggers: opcode ≥ 7, or mode=11 with op0..op2, or nssel=10 with an opcode outside op0..op2.
  - Response: illegal pulses for 1 cycle, state → HALT, address=0 in that same cycle; instr_count does not increment.
- Zero flag: zero_we=1 → flag <= alu_zero at the clock edge, independent of stall. A write in the same cycle as an nssel=11 decode does not affect that decode, which uses the old value.
- upc_q <= address every cycle in RUN, including stalled cycles.
- Reset mid-stall or mid-dispatch: immediate return to the reset values; no pending state survives.

Decomposition:
- Shared package microseq_pkg holds:
  - field bit positions (DBIN_LSB, NSSEL_LSB, IRE_BIT, MEM_LSB)
  - nssel encodings NS_JUMP=00, NS_IDISP=01, NS_ODISP=10, NS_ZBR=11
  - opcode and mode constants
  - microstate address constants (START0=0 … START1=23)
  - FSM state enum
- One sub-module: microseq_dispatch, a combinational opcode/mode → address table with an illegal flag, covering both dispatch levels.

Test Plan:
- Reset release: reset_n 0→1 → address=0 for 1 cycle, then tracks controlword. Drive nssel=00, dbin=10111 → address=23.
- Fetch: controlword ire=1, nssel=01, mem_rdata=0x1000 (ST, mode00), mem_ready=1 → address=16, ir=0x1000 next edge, instr_count=1.
- Memory dispatch: mem_rdata=0x0400 (LD, mode01) → address=5. Then nssel=10 → address=10.
- Zero branch: zero_we=1 with alu_zero=1, then nssel=11, dbin=00110 → address=7. Repeat with flag 0 → address=6.
- Stall: memcntl=010, mem_ready=0 for 3 cycles with upc_q=23 → address=23 each cycle, no IR change, no count. Then mem_ready=1 → dispatch proceeds.
- Illegal: ire=1, nssel=01, mem_rdata=0xF000 → illegal=1 for one cycle, halted=1, address=0 held until reset_n pulse.

Source files
------------

// File: rtl/microseq_pkg.sv
// -----------------------------------------------------------------------------
// microseq_pkg
// Shared definitions for the microsequencer:
//   - bit positions of the control-word fields used by the sequencer
//   - next-address select (nssel) encodings
//   - instruction opcode / addressing-mode encodings
//   - control-store microstate addresses targeted by the dispatch tables
//   - sequencer FSM state type
// -----------------------------------------------------------------------------
package microseq_pkg;

  // Control word fields, LSB-first
  localparam int DBIN_LSB  = 0;
  localparam int DBIN_W    = 5;
  localparam int NSSEL_LSB = 5;
  localparam int IRE_BIT   = 7;
  localparam int MEM_LSB   = 8;
  localparam int MEM_W     = 3;

  // Next-address select
  localparam logic [1:0] NS_JUMP  = 2'b00;
  localparam logic [1:0] NS_IDISP = 2'b01;
  localparam logic [1:0] NS_ODISP = 2'b10;
  localparam logic [1:0] NS_ZBR   = 2'b11;

  // Opcodes (IR top nibble)
  localparam logic [3:0] OP_LD   = 4'd0;
  localparam logic [3:0] OP_ST   = 4'd1;
  localparam logic [3:0] OP_OP   = 4'd2;
  localparam logic [3:0] OP_BRZ  = 4'd3;
  localparam logic [3:0] OP_PUSH = 4'd4;
  localparam logic [3:0] OP_POP  = 4'd5;
  localparam logic [3:0] OP_TEST = 4'd6;

  // Addressing modes (IR bits below the opcode)
  localparam logic [1:0] MODE_REG = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_IMM = 2'b10;
  localparam logic [1:0] MODE_BAD = 2'b11;

  // Microstate addresses in the control store
  localparam logic [4:0] US_START0 = 5'd0;
  localparam logic [4:0] US_IMM    = 5'd1;
  localparam logic [4:0] US_MEM    = 5'd5;
  localparam logic [4:0] US_BRZ    = 5'd9;
  localparam logic [4:0] US_LD_X   = 5'd10;
  localparam logic [4:0] US_ST_X   = 5'd11;
  localparam logic [4:0] US_OP_X   = 5'd12;
  localparam logic [4:0] US_TEST   = 5'd14;
  localparam logic [4:0] US_LD_R   = 5'd15;
  localparam logic [4:0] US_ST_R   = 5'd16;
  localparam logic [4:0] US_OP_R   = 5'd17;
  localparam logic [4:0] US_POP    = 5'd19;
  localparam logic [4:0] US_PUSH   = 5'd21;
  localparam logic [4:0] US_START1 = 5'd23;

  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_RUN      = 2'd1,
    ST_HALT     = 2'd2
  } seq_state_t;

endpackage

// File: rtl/microseq_dispatch.sv
// -----------------------------------------------------------------------------
// microseq_dispatch
// Combinational opcode/mode -> microstate address table for both dispatch
// levels, with an illegal flag for encodings that have no target.
// Ports:
//   i_opcode    4-bit instruction opcode
//   i_mode      2-bit addressing mode
//   i_op_level  0 = instruction dispatch (opcode+mode), 1 = operation dispatch
//   o_addr      target microstate (0 when illegal)
//   o_illegal   no valid target for this opcode/mode at this level
// -----------------------------------------------------------------------------
module microseq_dispatch
  import microseq_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [3:0]    i_opcode,
  input  logic [1:0]    i_mode,
  input  logic          i_op_level,
  output logic [AW-1:0] o_addr,
  output logic          o_illegal
);

  always_comb begin
    o_addr    = '0;
    o_illegal = 1'b0;
    if (i_op_level) begin
      // Operation dispatch: only the three operand-carrying opcodes have an execute state
      case (i_opcode)
        OP_LD:   o_addr = AW'(US_LD_X);
        OP_ST:   o_addr = AW'(US_ST_X);
        OP_OP:   o_addr = AW'(US_OP_X);
        default: o_illegal = 1'b1;
      endcase
    end else begin
      case (i_opcode)
        OP_LD, OP_ST, OP_OP: begin
          case (i_mode)
            MODE_MEM: o_addr = AW'(US_MEM);
            MODE_IMM: o_addr = AW'(US_IMM);
            MODE_REG: begin
              case (i_opcode)
                OP_LD:   o_addr = AW'(US_LD_R);
                OP_ST:   o_addr = AW'(US_ST_R);
                default: o_addr = AW'(US_OP_R);
              endcase
            end
            default:  o_illegal = 1'b1;
          endcase
        end
        // Mode field is don't-care for these
        OP_BRZ:  o_addr = AW'(US_BRZ);
        OP_PUSH: o_addr = AW'(US_PUSH);
        OP_POP:  o_addr = AW'(US_POP);
        OP_TEST: o_addr = AW'(US_TEST);
        default: o_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/microsequencer.sv
// -----------------------------------------------------------------------------
// microsequencer
// Next-address generator closing the microprogram loop around the control
// store. Decodes dbin/nssel/ire/memcntl of the registered control word and
// owns the instruction register, zero flag, memory-wait stall and the
// illegal-instruction halt.
// Ports:
//   clock, reset_n        rising-edge clock, async active-low reset
//   controlword           registered control word from the control store
//   mem_rdata, mem_ready  memory read data (instruction source), access done
//   alu_zero, zero_we     zero result and its latch enable
//   address               control-store address (next microstate)
//   ir                    instruction register
//   halted                sequencer stopped after an illegal dispatch
//   illegal               single-cycle pulse on the illegal dispatch
//   instr_count           number of instructions dispatched (wrapping)
// -----------------------------------------------------------------------------
module microsequencer
  import microseq_pkg::*;
#(
  parameter int AW   = 5,
  parameter int CW   = 25,
  parameter int IRW  = 16,
  parameter int CNTW = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [CW-1:0]   controlword,
  input  logic [IRW-1:0]  mem_rdata,
  input  logic            mem_ready,
  input  logic            alu_zero,
  input  logic            zero_we,
  output logic [AW-1:0]   address,
  output logic [IRW-1:0]  ir,
  output logic            halted,
  output logic            illegal,
  output logic [CNTW-1:0] instr_count
);

  seq_state_t      r_state;
  seq_state_t      w_state_nxt;
  logic [AW-1:0]   r_upc;
  logic [IRW-1:0]  r_ir;
  logic            r_zf;
  logic [CNTW-1:0] r_cnt;

  logic [DBIN_W-1:0] w_dbin;
  logic [1:0]        w_nssel;
  logic              w_ire;
  logic [MEM_W-1:0]  w_memcntl;
  logic              w_stall;
  logic [3:0]        w_opcode;
  logic [1:0]        w_mode;
  logic [AW-1:0]     w_disp_addr;
  logic              w_disp_illegal;
  logic [AW-1:0]     w_addr;
  logic              w_illegal;
  logic              w_ir_we;
  logic              w_count_en;
  logic              w_unused_fields;

  assign w_dbin    = controlword[DBIN_LSB +: DBIN_W];
  assign w_nssel   = controlword[NSSEL_LSB +: 2];
  assign w_ire     = controlword[IRE_BIT];
  assign w_memcntl = controlword[MEM_LSB +: MEM_W];
  // Datapath fields (alu/bdest/bsrc/adest/asrc) belong to other blocks
  assign w_unused_fields = ^controlword[CW-1:MEM_LSB+MEM_W];

  assign w_stall = (w_memcntl != '0) && !mem_ready;

  // Bypass: while the IR is being loaded, dispatch off the incoming word
  assign w_opcode = w_ire ? mem_rdata[IRW-1 -: 4] : r_ir[IRW-1 -: 4];
  assign w_mode   = w_ire ? mem_rdata[IRW-5 -: 2] : r_ir[IRW-5 -: 2];

  microseq_dispatch #(.AW(AW)) u_dispatch (
    .i_opcode   (w_opcode),
    .i_mode     (w_mode),
    .i_op_level (w_nssel == NS_ODISP),
    .o_addr     (w_disp_addr),
    .o_illegal  (w_disp_illegal)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_addr      = '0;
    w_illegal   = 1'b0;
    w_ir_we     = 1'b0;
    w_count_en  = 1'b0;
    case (r_state)
      // Address held at 0 so the control store loads start0 on the first edge
      ST_RST_HOLD: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_stall) begin
          // Reissue the last address so the control store reloads the same word
          w_addr = r_upc;
        end else begin
          w_ir_we = w_ire;
          case (w_nssel)
            NS_JUMP: w_addr = AW'(w_dbin);
            NS_ZBR:  w_addr = AW'({w_dbin[DBIN_W-1:1], r_zf});
            default: begin
              if (w_disp_illegal) begin
                w_illegal   = 1'b1;
                w_state_nxt = ST_HALT;
              end else begin
                w_addr     = w_disp_addr;
                w_count_en = (w_nssel == NS_IDISP);
              end
            end
          endcase
        end
      end
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_HALT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RST_HOLD;
      r_upc   <= '0;
      r_ir    <= '0;
      r_zf    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_RUN) r_upc <= w_addr;
      if (w_ir_we)           r_ir  <= mem_rdata;
      // Zero flag is written regardless of stall; a same-cycle ZBR decode sees the old value
      if (zero_we)           r_zf  <= alu_zero;
      if (w_count_en)        r_cnt <= r_cnt + CNTW'(1);
    end
  end

  assign address     = w_addr;
  assign illegal     = w_illegal;
  assign halted      = (r_state == ST_HALT);
  assign ir          = r_ir;
  assign instr_count = r_cnt;

endmodule

// File: tb/tb_microsequencer.sv
// -----------------------------------------------------------------------------
// tb_microsequencer
// Directed stimulus with hand-computed expectations pushed into a scoreboard
// queue; a monitor on the falling edge pops and compares every output.
// -----------------------------------------------------------------------------
module tb_microsequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [24:0] controlword;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        alu_zero;
  logic        zero_we;
  logic [4:0]  address;
  logic [15:0] ir;
  logic        halted;
  logic        illegal;
  logic [15:0] instr_count;

  always #5 clock = ~clock;

  microsequencer #(.AW(5), .CW(25), .IRW(16), .CNTW(16)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .controlword (controlword),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .alu_zero    (alu_zero),
    .zero_we     (zero_we),
    .address     (address),
    .ir          (ir),
    .halted      (halted),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  typedef struct {
    int          id;
    logic [4:0]  addr;
    logic [15:0] ir;
    logic        halted;
    logic        illegal;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Unused datapath fields carry a nonzero pattern to show they are ignored
  function automatic logic [24:0] mkcw(input logic [2:0] mem, input logic ire,
                                       input logic [1:0] ns, input logic [4:0] dbin);
    return {14'h2AAA, mem, ire, ns, dbin};
  endfunction

  task automatic chk(input int id, input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL step%0d %s: got 0x%0h expected 0x%0h", id, nm, got, want);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and record what the
  // outputs must show during that cycle.
  task automatic step(input int id, input logic rstn, input logic [24:0] cw,
                      input logic [15:0] rd, input logic rdy, input logic az,
                      input logic zwe, input logic [4:0] ea, input logic [15:0] eir,
                      input logic eh, input logic ei, input logic [15:0] ec);
    exp_t e;
    @(posedge clock);
    #1;
    reset_n     = rstn;
    controlword = cw;
    mem_rdata   = rd;
    mem_ready   = rdy;
    alu_zero    = az;
    zero_we     = zwe;
    e.id = id; e.addr = ea; e.ir = eir; e.halted = eh; e.illegal = ei; e.cnt = ec;
    sb_q.push_back(e);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.id, "address",     32'(address),     32'(e.addr));
      chk(e.id, "ir",          32'(ir),          32'(e.ir));
      chk(e.id, "halted",      32'(halted),      32'(e.halted));
      chk(e.id, "illegal",     32'(illegal),     32'(e.illegal));
      chk(e.id, "instr_count", 32'(instr_count), 32'(e.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    controlword = '0;
    mem_rdata   = '0;
    mem_ready   = 1'b1;
    alu_zero    = 1'b0;
    zero_we     = 1'b0;

    //     id rst cw                               rdata    rdy az zwe  addr ir       h  i  cnt
    // Reset state, then one start0 cycle after release, then jump to 23
    step(0,  0, mkcw(3'b000, 0, 2'b00, 5'd23), 16'h0000, 1, 0, 0, 5'd0,  16'h0000, 0, 0, 16'd0);
    step(1,  1, mkcw(3'b000, 0, 2'b00, 5'd23), 16'h0000, 1, 0, 0, 5'd0,  16'h0000, 0, 0, 16'd0);
    step(2,  1, mkcw(3'b000, 0, 2'b00, 5'd23), 16'h0000, 1, 0, 0, 5'd23, 16'h0000, 0, 0, 16'd0);
    // Fetch ST mode00 with bypass, then LD mode01, then operation dispatch on LD
    step(3,  1, mkcw(3'b001, 1, 2'b01, 5'd0),  16'h1000, 1, 0, 0, 5'd16, 16'h0000, 0, 0, 16'd0);
    step(4,  1, mkcw(3'b001, 1, 2'b01, 5'd0),  16'h0400, 1, 0, 0, 5'd5,  16'h1000, 0, 0, 16'd1);
    step(5,  1, mkcw(3'b000, 0, 2'b10, 5'd0),  16'h0000, 1, 0, 0, 5'd10, 16'h0400, 0, 0, 16'd2);
    // Zero branch: same-cycle write is not seen, next cycle it is
    step(6,  1, mkcw(3'b000, 0, 2'b11, 5'd6),  16'h0000, 1, 1, 1, 5'd6,  16'h0400, 0, 0, 16'd2);
    step(7,  1, mkcw(3'b000, 0, 2'b11, 5'd6),  16'h0000, 1, 0, 0, 5'd7,  16'h0400, 0, 0, 16'd2);
    step(8,  1, mkcw(3'b000, 0, 2'b11, 5'd6),  16'h0000, 1, 0, 1, 5'd7,  16'h0400, 0, 0, 16'd2);
    step(9,  1, mkcw(3'b000, 0, 2'b11, 5'd6),  16'h0000, 1, 0, 0, 5'd6,  16'h0400, 0, 0, 16'd2);
    // Stall for 3 cycles reissuing 23, then the OP mode00 dispatch goes through
    step(10, 1, mkcw(3'b000, 0, 2'b00, 5'd23), 16'h0000, 1, 0, 0, 5'd23, 16'h0400, 0, 0, 16'd2);
    step(11, 1, mkcw(3'b010, 1, 2'b01, 5'd0),  16'h2000, 0, 0, 0, 5'd23, 16'h0400, 0, 0, 16'd2);
    step(12, 1, mkcw(3'b010, 1, 2'b01, 5'd0),  16'h2000, 0, 0, 0, 5'd23, 16'h0400, 0, 0, 16'd2);
    step(13, 1, mkcw(3'b010, 1, 2'b01, 5'd0),  16'h2000, 0, 0, 0, 5'd23, 16'h0400, 0, 0, 16'd2);
    step(14, 1, mkcw(3'b010, 1, 2'b01, 5'd0),  16'h2000, 1, 0, 0, 5'd17, 16'h0400, 0, 0, 16'd2);
    step(15, 1, mkcw(3'b000, 0, 2'b00, 5'd3),  16'h0000, 1, 0, 0, 5'd3,  16'h2000, 0, 0, 16'd3);
    // Mode-insensitive opcodes, immediate mode, operation dispatch on ST
    step(16, 1, mkcw(3'b001, 1, 2'b01, 5'd0),  16'h3C00, 1, 0, 0, 5'd9,  16'h2000, 0, 0, 16'd3);
    step(17, 1, mkcw(3'b001, 1, 2'b01, 5'd0),  16'h4000, 1, 0, 0, 5'd21, 16'h3C00, 0, 0, 16'd4);
    step(18, 1, mkcw(3'b001, 1, 2'b01, 5'd0),  16'h5000, 1, 0, 0, 5'd19, 16'h4000, 0, 0, 16'd5);
    step(19, 1, mkcw(3'b001, 1, 2'b01, 5'd0),  16'h6000, 1, 0, 0, 5'd14, 16'h5000, 0, 0, 16'd6);
    step(20, 1, mkcw(3'b001, 1, 2'b01, 5'd0),  16'h1800, 1, 0, 0, 5'd1,  16'h6000, 0, 0, 16'd7);
    step(21, 1, mkcw(3'b000, 0, 2'b10, 5'd0),  16'h0000, 1, 0, 0, 5'd11, 16'h1800, 0, 0, 16'd8);
    // LD mode11 is illegal: pulse, then halt holding address 0
    step(22, 1, mkcw(3'b001, 1, 2'b01, 5'd0),  16'h0C00, 1, 0, 0, 5'd0,  16'h1800, 0, 1, 16'd8);
    step(23, 1, mkcw(3'b000, 0, 2'b00, 5'd23), 16'h0000, 1, 0, 0, 5'd0,  16'h0C00, 1, 0, 16'd8);
    step(24, 1, mkcw(3'b000, 0, 2'b00, 5'd23), 16'h0000, 1, 0, 0, 5'd0,  16'h0C00, 1, 0, 16'd8);
    // Reset out of HALT, then opcode 15 fetch is illegal
    step(25, 0, mkcw(3'b000, 0, 2'b00, 5'd23), 16'h0000, 1, 0, 0, 5'd0,  16'h0000, 0, 0, 16'd0);
    step(26, 1, mkcw(3'b000, 0, 2'b00, 5'd23), 16'h0000, 1, 0, 0, 5'd0,  16'h0000, 0, 0, 16'd0);
    step(27, 1, mkcw(3'b000, 0, 2'b00, 5'd23), 16'h0000, 1, 0, 0, 5'd23, 16'h0000, 0, 0, 16'd0);
    step(28, 1, mkcw(3'b001, 1, 2'b01, 5'd0),  16'hF000, 1, 0, 0, 5'd0,  16'h0000, 0, 1, 16'd0);
    step(29, 1, mkcw(3'b000, 0, 2'b00, 5'd23), 16'h0000, 1, 0, 0, 5'd0,  16'hF000, 1, 0, 16'd0);
    step(30, 1, mkcw(3'b000, 0, 2'b00, 5'd23), 16'h0000, 1, 0, 0, 5'd0,  16'hF000, 1, 0, 16'd0);
    // Operation dispatch on BRZ is illegal, but not while stalled
    step(31, 0, mkcw(3'b000, 0, 2'b00, 5'd0),  16'h0000, 1, 0, 0, 5'd0,  16'h0000, 0, 0, 16'd0);
    step(32, 1, mkcw(3'b000, 0, 2'b00, 5'd0),  16'h0000, 1, 0, 0, 5'd0,  16'h0000, 0, 0, 16'd0);
    step(33, 1, mkcw(3'b000, 1, 2'b00, 5'd4),  16'h3000, 1, 0, 0, 5'd4,  16'h0000, 0, 0, 16'd0);
    step(34, 1, mkcw(3'b001, 0, 2'b10, 5'd0),  16'h0000, 0, 0, 0, 5'd4,  16'h3000, 0, 0, 16'd0);
    step(35, 1, mkcw(3'b001, 0, 2'b10, 5'd0),  16'h0000, 1, 0, 0, 5'd0,  16'h3000, 0, 1, 16'd0);
    step(36, 1, mkcw(3'b000, 0, 2'b00, 5'd0),  16'h0000, 1, 0, 0, 5'd0,  16'h3000, 1, 0, 16'd0);

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clock);
    @(posedge clock);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
